// File: rtl/avl_accum_pkg.sv
// Shared constants for the switch-accumulate Avalon-MM peripheral.
// Register addresses plus STATUS/CTRL bit positions.
package avl_accum_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_SWITCH = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   localparam int ST_ACC = 0;
   localparam int ST_CLR = 1;
   localparam int ST_OVF = 2;

   localparam int CT_HWEN  = 0;
   localparam int CT_IRQEN = 1;

endpackage

// File: rtl/avalon_sw_accum_key_debounce.sv
// Active-low push-button conditioner: 2-FF sync, stability counter,
// debounced level and a one-cycle press pulse on a 1->0 level change.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = key_n;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      // any cycle that agrees with the current level restarts the count
      if (sync2_q != level_q) begin
         if (cnt_q == LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = level_q & ~level_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/avalon_sw_accum.sv
// Avalon-MM switch-accumulate peripheral: debounced keys add SW into an
// 8-bit accumulator shown on LED, with sticky status and a level IRQ.
module avalon_sw_accum
   import avl_accum_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        AVL_CS,
   input  logic        AVL_READ,
   input  logic        AVL_WRITE,
   input  logic [1:0]  AVL_ADDR,
   input  logic [31:0] AVL_WRITEDATA,
   output logic [31:0] AVL_READDATA,
   input  logic [7:0]  SW,
   input  logic        KEY_ACC_N,
   input  logic        KEY_CLR_N,
   output logic [7:0]  LED,
   output logic        IRQ
);

   logic        acc_press, clr_press;
   logic        wr, rd;
   logic [8:0]  sum;
   logic [7:0]  sw_s1_q, sw_s1_d;
   logic [7:0]  sw_s2_q, sw_s2_d;
   logic [7:0]  acc_q, acc_d;
   logic [2:0]  status_q, status_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic [31:0] rdata_q, rdata_d;
   logic        unused_wdata;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_acc (
      .clk   (CLK),
      .rst   (RESET),
      .key_n (KEY_ACC_N),
      .press (acc_press)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clr (
      .clk   (CLK),
      .rst   (RESET),
      .key_n (KEY_CLR_N),
      .press (clr_press)
   );

   assign unused_wdata = ^AVL_WRITEDATA[31:8];

   always_comb begin
      wr       = AVL_CS & AVL_WRITE;
      rd       = AVL_CS & AVL_READ;
      sw_s1_d  = SW;
      sw_s2_d  = sw_s1_q;
      sum      = {1'b0, acc_q} + {1'b0, sw_s2_q};
      acc_d    = acc_q;
      status_d = status_q;
      ctrl_d   = ctrl_q;
      rdata_d  = rdata_q;

      if (wr && AVL_ADDR == ADDR_STATUS) begin
         status_d = status_q & ~AVL_WRITEDATA[2:0];
      end
      if (wr && AVL_ADDR == ADDR_CTRL) begin
         ctrl_d = AVL_WRITEDATA[1:0];
      end

      // hardware sets land after the W1C so a coincident set wins
      if (acc_press) status_d[ST_ACC] = 1'b1;
      if (clr_press) status_d[ST_CLR] = 1'b1;

      if (clr_press) begin
         acc_d = 8'h00;
      end else if (wr && AVL_ADDR == ADDR_DATA) begin
         acc_d = AVL_WRITEDATA[7:0];
      end else if (acc_press && ctrl_q[CT_HWEN]) begin
         acc_d = sum[7:0];
         if (sum[8]) status_d[ST_OVF] = 1'b1;
      end

      if (rd) begin
         unique case (AVL_ADDR)
            ADDR_DATA:   rdata_d = {24'h0, acc_q};
            ADDR_SWITCH: rdata_d = {24'h0, sw_s2_q};
            ADDR_STATUS: rdata_d = {29'h0, status_q};
            ADDR_CTRL:   rdata_d = {30'h0, ctrl_q};
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sw_s1_q  <= 8'h00;
         sw_s2_q  <= 8'h00;
         acc_q    <= 8'h00;
         status_q <= 3'h0;
         ctrl_q   <= 2'h0;
         rdata_q  <= 32'h0;
      end else begin
         sw_s1_q  <= sw_s1_d;
         sw_s2_q  <= sw_s2_d;
         acc_q    <= acc_d;
         status_q <= status_d;
         ctrl_q   <= ctrl_d;
         rdata_q  <= rdata_d;
      end
   end

   assign AVL_READDATA = rdata_q;
   assign LED          = acc_q;
   assign IRQ          = ctrl_q[CT_IRQEN] & (status_q[ST_ACC] | status_q[ST_CLR]);

endmodule

// File: tb/tb_avalon_sw_accum.sv
// Bench for avalon_sw_accum with DEBOUNCE_CYCLES=4 and a register-level
// reference model of acc/STATUS/CTRL updated from the register rules.
module tb_avalon_sw_accum;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        AVL_CS = 1'b0;
   logic        AVL_READ = 1'b0;
   logic        AVL_WRITE = 1'b0;
   logic [1:0]  AVL_ADDR = 2'd0;
   logic [31:0] AVL_WRITEDATA = 32'h0;
   logic [31:0] AVL_READDATA;
   logic [7:0]  SW = 8'h00;
   logic        KEY_ACC_N = 1'b1;
   logic        KEY_CLR_N = 1'b1;
   logic [7:0]  LED;
   logic        IRQ;

   int total = 0;
   int bad = 0;

   int         m_acc;
   logic [2:0] m_st;
   logic [1:0] m_ctrl;

   avalon_sw_accum #(.DEBOUNCE_CYCLES(4)) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .AVL_CS        (AVL_CS),
      .AVL_READ      (AVL_READ),
      .AVL_WRITE     (AVL_WRITE),
      .AVL_ADDR      (AVL_ADDR),
      .AVL_WRITEDATA (AVL_WRITEDATA),
      .AVL_READDATA  (AVL_READDATA),
      .SW            (SW),
      .KEY_ACC_N     (KEY_ACC_N),
      .KEY_CLR_N     (KEY_CLR_N),
      .LED           (LED),
      .IRQ           (IRQ)
   );

   always #5 CLK = ~CLK;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      AVL_CS = 1'b1; AVL_WRITE = 1'b1;
      AVL_ADDR = a; AVL_WRITEDATA = d;
      tick();
      AVL_CS = 1'b0; AVL_WRITE = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
      tick();
      AVL_CS = 1'b0; AVL_READ = 1'b0;
      d = AVL_READDATA;
   endtask

   // Key goes low after an edge; the event is applied on the 7th edge.
   // An optional Avalon write is presented on that same 7th edge.
   task automatic press(input bit is_clr, input bit do_wr,
                        input logic [1:0] a, input logic [31:0] d,
                        output logic [7:0] led6, output logic [7:0] led7);
      if (is_clr) KEY_CLR_N = 1'b0; else KEY_ACC_N = 1'b0;
      tick(6);
      led6 = LED;
      if (do_wr) begin
         AVL_CS = 1'b1; AVL_WRITE = 1'b1;
         AVL_ADDR = a; AVL_WRITEDATA = d;
      end
      tick();
      AVL_CS = 1'b0; AVL_WRITE = 1'b0;
      led7 = LED;
      KEY_ACC_N = 1'b1; KEY_CLR_N = 1'b1;
      tick(10);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick(2);
      RESET = 1'b0;
      m_acc = 0; m_st = 3'b000; m_ctrl = 2'b00;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [7:0]  sw;
      sw = 8'($urandom);
      SW = sw;
      do_reset();
      tick(3);
      rd(2'd0, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", d); end
      rd(2'd1, d);
      total++;
      if (d !== {24'h0, sw}) begin bad++; $display("FAIL reset_switch got=%h exp=%h", d, sw); end
      rd(2'd2, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
      rd(2'd3, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", d); end
      total++;
      if (LED !== 8'h00 || IRQ !== 1'b0) begin
         bad++; $display("FAIL reset_led_irq led=%h irq=%b exp 00/0", LED, IRQ);
      end
   endtask

   task automatic test_accum();
      logic [31:0] d;
      logic [7:0]  l6, l7;
      wr(2'd3, 32'h1); m_ctrl = 2'b01;
      SW = 8'h30;
      tick(3);
      press(1'b0, 1'b0, 2'd0, 32'h0, l6, l7);
      m_acc = (m_acc + 8'h30) % 256; m_st[0] = 1'b1;
      total++;
      if (l6 !== 8'h00) begin bad++; $display("FAIL acc_early got=%h exp=00", l6); end
      total++;
      if (l7 !== 8'(m_acc)) begin bad++; $display("FAIL acc_cycle7 got=%h exp=%h", l7, m_acc); end
      rd(2'd2, d);
      total++;
      if (d !== 32'h1) begin bad++; $display("FAIL acc_status got=%h exp=1", d); end
      total++;
      if (IRQ !== 1'b0) begin bad++; $display("FAIL irq_disabled got=%b exp=0", IRQ); end
      wr(2'd3, 32'h3); m_ctrl = 2'b11;
      total++;
      if (IRQ !== 1'b1) begin bad++; $display("FAIL irq_enabled got=%b exp=1", IRQ); end
      wr(2'd2, 32'h1); m_st[0] = 1'b0;
      total++;
      if (IRQ !== 1'b0) begin bad++; $display("FAIL irq_w1c got=%b exp=0", IRQ); end
   endtask

   task automatic test_overflow_bounce();
      logic [31:0] d;
      logic [7:0]  l6, l7;
      wr(2'd0, 32'hF0); m_acc = 'hF0;
      wr(2'd3, 32'h1); m_ctrl = 2'b01;
      SW = 8'h20;
      tick(3);
      press(1'b0, 1'b0, 2'd0, 32'h0, l6, l7);
      if (m_acc + 'h20 > 255) m_st[2] = 1'b1;
      m_acc = (m_acc + 'h20) % 256; m_st[0] = 1'b1;
      total++;
      if (l7 !== 8'h10) begin bad++; $display("FAIL ovf_acc got=%h exp=10", l7); end
      rd(2'd2, d);
      total++;
      if (d !== {29'h0, m_st}) begin bad++; $display("FAIL ovf_status got=%h exp=%h", d, m_st); end
      wr(2'd2, 32'h7); m_st = 3'b000;
      KEY_ACC_N = 1'b0;
      tick(3);
      KEY_ACC_N = 1'b1;
      tick(12);
      total++;
      if (LED !== 8'(m_acc)) begin bad++; $display("FAIL bounce_acc got=%h exp=%h", LED, m_acc); end
      rd(2'd2, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL bounce_status got=%h exp=0", d); end
   endtask

   task automatic test_priority();
      logic [31:0] d;
      logic [7:0]  l6, l7;
      wr(2'd0, 32'h3C); m_acc = 'h3C;
      press(1'b1, 1'b1, 2'd0, 32'h55, l6, l7);
      m_acc = 0; m_st[1] = 1'b1;
      total++;
      if (l7 !== 8'(m_acc)) begin bad++; $display("FAIL clr_vs_write got=%h exp=%h", l7, m_acc); end
      rd(2'd2, d);
      total++;
      if (d !== {29'h0, m_st}) begin bad++; $display("FAIL clr_status got=%h exp=%h", d, m_st); end
      wr(2'd2, 32'h7); m_st = 3'b000;
      wr(2'd3, 32'h1); m_ctrl = 2'b01;
      SW = 8'h11;
      tick(3);
      press(1'b0, 1'b1, 2'd0, 32'h55, l6, l7);
      m_acc = 'h55; m_st[0] = 1'b1;
      total++;
      if (l7 !== 8'(m_acc)) begin bad++; $display("FAIL acc_vs_write got=%h exp=%h", l7, m_acc); end
      rd(2'd2, d);
      total++;
      if (d !== {29'h0, m_st}) begin bad++; $display("FAIL accw_status got=%h exp=%h", d, m_st); end
   endtask

   task automatic test_w1c_race();
      logic [31:0] d;
      logic [7:0]  l6, l7;
      wr(2'd2, 32'h7); m_st = 3'b000;
      press(1'b0, 1'b1, 2'd2, 32'h1, l6, l7);
      m_st[0] = 1'b1;
      if (m_ctrl[0]) begin
         if (m_acc + SW > 255) m_st[2] = 1'b1;
         m_acc = (m_acc + SW) % 256;
      end
      rd(2'd2, d);
      total++;
      if (d !== {29'h0, m_st}) begin bad++; $display("FAIL w1c_race got=%h exp=%h", d, m_st); end
      total++;
      if (LED !== 8'(m_acc)) begin bad++; $display("FAIL w1c_race_acc got=%h exp=%h", LED, m_acc); end
   endtask

   task automatic test_reset_midcount();
      logic [31:0] d;
      logic [7:0]  l6, l7;
      wr(2'd0, 32'h77);
      KEY_ACC_N = 1'b0;
      tick(4);
      RESET = 1'b1; KEY_ACC_N = 1'b1;
      tick(2);
      RESET = 1'b0;
      m_acc = 0; m_st = 3'b000; m_ctrl = 2'b00;
      tick(12);
      rd(2'd2, d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL midcount_status got=%h exp=0", d); end
      total++;
      if (LED !== 8'h00) begin bad++; $display("FAIL midcount_acc got=%h exp=00", LED); end
      wr(2'd0, 32'h5A); m_acc = 'h5A;
      SW = 8'h0F;
      tick(3);
      press(1'b0, 1'b0, 2'd0, 32'h0, l6, l7);
      m_st[0] = 1'b1;
      rd(2'd2, d);
      total++;
      if (d !== {29'h0, m_st}) begin bad++; $display("FAIL hwen0_status got=%h exp=%h", d, m_st); end
      total++;
      if (LED !== 8'(m_acc)) begin bad++; $display("FAIL hwen0_acc got=%h exp=%h", LED, m_acc); end
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic [7:0]  l6, l7;
      logic [7:0]  sw, init;
      logic [1:0]  c;
      for (int i = 0; i < 8; i++) begin
         init = 8'($urandom);
         sw   = 8'($urandom);
         c    = 2'($urandom_range(3, 0));
         wr(2'd2, 32'h7); m_st = 3'b000;
         wr(2'd0, {24'h0, init}); m_acc = init;
         wr(2'd3, {30'h0, c}); m_ctrl = c;
         SW = sw;
         tick(3);
         rd(2'd1, d);
         total++;
         if (d !== {24'h0, sw}) begin bad++; $display("FAIL rnd_switch i=%0d got=%h exp=%h", i, d, sw); end
         press(1'b0, 1'b0, 2'd0, 32'h0, l6, l7);
         m_st[0] = 1'b1;
         if (m_ctrl[0]) begin
            if (m_acc + sw > 255) m_st[2] = 1'b1;
            m_acc = (m_acc + sw) % 256;
         end
         total++;
         if (l7 !== 8'(m_acc)) begin bad++; $display("FAIL rnd_acc i=%0d got=%h exp=%h", i, l7, m_acc); end
         rd(2'd2, d);
         total++;
         if (d !== {29'h0, m_st}) begin bad++; $display("FAIL rnd_status i=%0d got=%h exp=%h", i, d, m_st); end
         total++;
         if (IRQ !== m_ctrl[1]) begin bad++; $display("FAIL rnd_irq i=%0d got=%b exp=%b", i, IRQ, m_ctrl[1]); end
         rd(2'd0, d);
         total++;
         if (d !== 32'(m_acc)) begin bad++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, d, m_acc); end
      end
   endtask

   initial begin
      test_reset();
      test_accum();
      test_overflow_bounce();
      test_priority();
      test_w1c_race();
      test_reset_midcount();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/avalon_sw_accum.md
# avalon_sw_accum

Avalon-MM slave peripheral: the hardware end of the Nios II switch-accumulate interface. Debounces the accumulate and clear push-buttons, captures press events, adds the switch value into an 8-bit accumulator, drives the LEDs, and raises an interrupt. The Nios II master reads and writes the accumulator, status and control registers. The block sits in the FPGA fabric beside the SoC and replaces raw PIO polling of KEY and SW.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles a key must hold before its debounced level changes (10 ms at 50 MHz).

Ports:
- CLK  in  1  system clock (CLOCK_50 domain). The block uses one clock.
- RESET  in  1  synchronous, active-high reset.
- AVL_CS  in  1  chip select.
- AVL_READ  in  1  read strobe, qualified by AVL_CS.
- AVL_WRITE  in  1  write strobe, qualified by AVL_CS.
- AVL_ADDR  in  2  word address.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data, registered.
- SW  in  8  slide switches, asynchronous.
- KEY_ACC_N  in  1  accumulate button, active-low, asynchronous.
- KEY_CLR_N  in  1  clear button, active-low, asynchronous.
- LED  out  8  equal to the accumulator.
- IRQ  out  1  level interrupt.

## Operation

Register map (word addresses):
- 0 DATA: accumulator, read/write. A write loads AVL_WRITEDATA[7:0]; bits 31:8 read as 0.
- 1 SWITCH: synchronized SW value, read-only. Writes are ignored.
- 2 STATUS: bit0 ACC_EV, bit1 CLR_EV, bit2 OVF. All bits are sticky. Writing 1 to a bit clears it.
- 3 CTRL: bit0 HW_EN (hardware accumulates on an ACC press), bit1 IRQ_EN. Read/write.

Key and switch handling:
- Each key passes through a 2-FF synchronizer, then the debouncer.
- The debounced level starts at 1 (released). It flips only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any cycle where they match resets the counter.
- A press event is one cycle on a 1→0 transition of the debounced level. A release produces no event.
- SW passes through a 2-FF synchronizer.

Press handling:
- ACC press: set ACC_EV. If HW_EN=1, set acc ← acc + SW_sync mod 256. If the true sum exceeds 255, set OVF.
- CLR press: set CLR_EV and set acc ← 0.

Priority for acc in a single cycle: CLR press, then Avalon DATA write, then ACC accumulate. The lower-priority actions are dropped; ACC_EV and CLR_EV are still set.

Status bits:
- A STATUS write-1-to-clear and a hardware set on the same bit in the same cycle: the set wins.
- IRQ = IRQ_EN & (ACC_EV | CLR_EV). OVF does not interrupt.

Reset values:
- acc, LED, STATUS, CTRL, AVL_READDATA, IRQ: 0.
- Debounced levels: 1. Debounce counters: 0.
- Synchronizers: 1 for keys, 0 for SW.
- A RESET asserted mid-count discards the count; no event is produced.

## Timing

- Read latency: 1 cycle. AVL_READDATA is valid the cycle after AVL_CS&AVL_READ and holds until the next read. There is no waitrequest.
- Writes take effect on the clock edge where AVL_CS&AVL_WRITE is sampled. A read in the following cycle returns the new value.
- Key latency: input edge at cycle 0; synchronized at cycle 2; debounced flips at cycle 2+DEBOUNCE_CYCLES; acc, STATUS and IRQ update at cycle 3+DEBOUNCE_CYCLES.
- LED follows acc combinationally from the acc register, so it has zero extra latency.
- Reads have no side effects.

## Structure

- Package avl_accum_pkg holds:
  - address constants ADDR_DATA, ADDR_SWITCH, ADDR_STATUS, ADDR_CTRL;
  - STATUS bit indices ST_ACC, ST_CLR, ST_OVF;
  - CTRL bit indices CT_HWEN, CT_IRQEN.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES) contains the synchronizer, counter, debounced level and one-cycle press pulse. It is instantiated twice, once per key.
- The top level holds the SW synchronizer, acc, STATUS, CTRL and the read mux.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

1. Reset, then read all four addresses. Required: DATA=0, SWITCH=SW, STATUS=0, CTRL=0; LED=0 and IRQ=0 throughout.
2. CTRL=1, SW=0x30, clean ACC press, wait. Required: acc=0x30 at cycle 7 after the edge, STATUS=0x1, IRQ=0. Then write CTRL=3. Required: IRQ=1; write STATUS=1 clears it to 0.
3. DATA←0xF0, HW_EN=1, SW=0x20, ACC press. Required: acc=0x10, OVF=1. A bounce pulse of 3 cycles on the key produces no event and acc is unchanged.
4. CLR press landing in the same cycle as an Avalon DATA←0x55 write. Required: acc=0, CLR_EV=1. An ACC press coincident with a DATA←0x55 write gives acc=0x55 with ACC_EV=1.
5. STATUS W1C of ACC_EV coinciding with a new ACC press event. Required: ACC_EV remains 1.
6. RESET asserted 2 cycles into a debounce count. Required: no event after release of RESET; HW_EN=0 press sets ACC_EV only, acc unchanged.
